// File: rtl/xor_stream_decoder.sv
// xor_stream_decoder: additive byte-stream descrambler.
// Each accepted word is XORed with the low DATA_W bits of a Galois LFSR. The
// LFSR then steps once. A frame opens with seed_load and closes with in_last.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   seed_load, seed_val   frame start pulse and LFSR seed (zero -> SEED_DEF)
//   in_valid/in_ready     encoded word handshake; in_data, in_last payload
//   out_valid/out_ready   decoded word handshake; out_data, out_last payload
//   byte_cnt              words accepted in the current frame, saturating
//   seed_err              one-cycle pulse for a seed_load outside IDLE
module xor_stream_decoder #(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       LFSR_W   = 16,
    parameter logic [LFSR_W-1:0] POLY     = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED_DEF = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_val,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [15:0]       byte_cnt,
    output logic              seed_err
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               seed_err_d;
    logic               accept;
    logic               xfer;

    // One Galois step: shift right, fold the feedback mask in when bit 0 was set.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    endfunction

    // Accept only in RUN and only when the output register is free or draining now.
    assign in_ready = (state_q == RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;

    // Next-state, keystream and counter logic.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        cnt_d      = byte_cnt;
        seed_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (seed_load) begin
                    lfsr_d  = (seed_val == '0) ? SEED_DEF : seed_val;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                seed_err_d = seed_load;
                if (accept) begin
                    lfsr_d = lfsr_step(lfsr_q);
                    if (byte_cnt != {CNT_W{1'b1}}) begin
                        cnt_d = byte_cnt + CNT_W'(1);
                    end
                    if (in_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                seed_err_d = seed_load;
                if (!out_valid || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, keystream, counter and error-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED_DEF;
            byte_cnt <= '0;
            seed_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            byte_cnt <= cnt_d;
            seed_err <= seed_err_d;
        end
    end

    // Output register: a new accept overwrites in the same cycle as a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data ^ lfsr_q[DATA_W-1:0];
            out_last  <= in_last;
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule
